oc_uart_rx: RTL and testbench
=============================

# oc_uart_rx

Oversampling 8N1 UART receiver. It turns the asynchronous serial `rx` pin into bytes on a valid/ready channel, buffered in a small FIFO. It sits directly upstream of the UART control console: its output channel drives the console's received-byte stream, and its error pulses feed the console's `uartError` bits. The console never backpressures for long, so the FIFO only absorbs short stalls, and overruns are reported rather than blocking the line.

## Interface
- `ClockHz`, 100_000_000: clock frequency.
- `Baud`, 115_200: line rate.
- `FifoDepth`, 4: output FIFO entries; power of 2, ≥2.
- `SyncStages`, 2: `rx` synchronizer flops, ≥2.

- `clock`  in  1  sole clock.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `rx`  in  1  serial input, idle high.
- `rxData`  out  8  FIFO head byte.
- `rxValid`  out  1  FIFO non-empty.
- `rxReady`  in  1  consumer accepts head when `rxValid && rxReady`.
- `errorFrame`  out  1  1-cycle pulse: stop bit sampled low.
- `errorOverrun`  out  1  1-cycle pulse: byte dropped, FIFO full.
- `breakDetect`  out  1  1-cycle pulse: break frame (see Configuration).

## Operation
**Tick generation**
- Divider `Div = (ClockHz + 8*Baud) / (16*Baud)`, an integer with rounding.
- `Div < 2` is an elaboration error.
- The tick counter free-runs only outside `Idle`. It restarts at 0 on the start edge.
- Each bit lasts 16 ticks, numbered 0–15.

**Sampling**
- `rx` passes through `SyncStages` flops, all reset to 1. The output is `rxS`.
- The bit value is the majority of `rxS` at ticks 7, 8 and 9, decided at tick 9.

**FSM** (`WaitIdle`, `Idle`, `Start`, `Data`, `Stop`)
- `WaitIdle`: this is the reset state. Go to `Idle` once `rxS` = 1.
- `Idle`: `rxS` = 0 → `Start`, with tick = 0.
- `Start`: at tick 9, majority 1 (glitch) → `Idle`, with no error. Otherwise at tick 15 → `Data`, with bit index 0.
- `Data`: shift the majority value into bit [index], LSB first. At tick 15: index 7 → `Stop`; else index+1.
- `Stop`, deciding at tick 9:
  - Majority 1: push the byte and go to `Idle`.
  - Majority 0: no push. Pulse `errorFrame`, or `breakDetect` per Configuration, then go to `WaitIdle`.

**FIFO**
- Push when the FIFO is not full. If full, pulse `errorOverrun`, drop the new byte and leave the contents intact.
- Push and pop in the same cycle while full: the pop frees a slot, the push succeeds and there is no overrun.
- Pop on `rxValid && rxReady`. `rxData` is valid whenever `rxValid` = 1.
- The read and write pointers are `log2(FifoDepth)+1` bits; wrap-around is natural.

**Reset**
- Asserting `reset` mid-frame clears everything immediately. The partial byte and FIFO contents are lost.
- After release, the block stays in `WaitIdle` until the line is high, so a frame in flight is never mis-framed.

## Timing
- Reset values:
  - `rxValid`=0, `rxData`=0.
  - All error and break pulses 0.
  - FIFO empty.
  - FSM `WaitIdle`.
  - Sync flops 1.
- Latency on `rx` to `rxS` is `SyncStages` cycles.
- The push is registered in the cycle of the stop-bit tick-9 decision. `rxValid` rises the next edge.
- `rxData` and `rxValid` are registered or FIFO-RAM outputs, with no combinational path from `rx`.
- `rxReady` to pop is combinational in the same cycle. The next head is visible the following cycle.
- Error pulses are registered and last exactly 1 cycle per event.
- Throughput: back-to-back frames with no idle gap are received, because `Idle` re-arms at stop tick 9.

## Configuration
- `OC_UART_RX_BREAK_DETECT_EN` defined:
  - A stop-bit failure with received data 0x00 pulses `breakDetect` instead of `errorFrame`.
  - The FSM then holds in `WaitIdle` until the line returns high, so only one pulse is produced however long the break lasts.
- Not defined:
  - `breakDetect` is tied 0.
  - Every stop-bit failure pulses `errorFrame`.

## Test plan
Bench: ClockHz=32_000_000, Baud=1_000_000, so Div=2 and 32 cycles per bit.

1. Send 0x55 then 0xA3 back-to-back, `rxReady`=1 → `rxData` 0x55 then 0xA3, one `rxValid` cycle each, no error pulses.
2. Drive `rx` low for 8 cycles then high; then send 0x41 → no byte from the glitch; 0x41 is received correctly.
3. Send 0x7E with stop bit forced 0, then line high, then 0x12 → exactly one `errorFrame`; 0x7E not delivered; 0x12 delivered.
4. Hold `rxReady`=0 and send 0x01–0x05 → one `errorOverrun` on 0x05; then `rxReady`=1 drains 0x01, 0x02, 0x03, 0x04 in order.
5. Hold `rx` low for 12 bit times, then high:
   - Macro defined: one `breakDetect`, no `errorFrame`.
   - Macro undefined: one `errorFrame`.
   - In both cases, a following 0x33 is received.
6. Assert `reset` during bit 3 of 0xC3 and release with `rx` still low; finish the frame; then send 0x5A → only 0x5A appears; no errors.

Source files
------------

// File: rtl/oc_uart_rx.sv
// oc_uart_rx: 16x-oversampling 8N1 UART receiver feeding a small byte FIFO.
// Latency: SyncStages cycles rx->rxS; a byte is written at the stop-bit tick-9 decision and rxValid rises on the next edge.
// Backpressure: rxReady pops the FIFO head combinationally; a byte arriving while the FIFO is full is dropped and flagged with errorOverrun.
//
// Optional feature macro: OC_UART_RX_BREAK_DETECT_EN (break frames pulse breakDetect instead of errorFrame).
//
// Ports:
//   clock        sole clock
//   reset        asynchronous active-low reset
//   rx           serial input, idle high
//   rxData       FIFO head byte (valid while rxValid)
//   rxValid      FIFO non-empty
//   rxReady      consumer accepts head when rxValid && rxReady
//   errorFrame   1-cycle pulse: stop bit sampled low
//   errorOverrun 1-cycle pulse: byte dropped because the FIFO was full
//   breakDetect  1-cycle pulse: all-zero frame with low stop bit (0 unless the macro is defined)
module oc_uart_rx #(
  parameter int ClockHz    = 100_000_000,
  parameter int Baud       = 115_200,
  parameter int FifoDepth  = 4,
  parameter int SyncStages = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rxData,
  output logic       rxValid,
  input  logic       rxReady,
  output logic       errorFrame,
  output logic       errorOverrun,
  output logic       breakDetect
);

  localparam int Div  = (ClockHz + 8 * Baud) / (16 * Baud);
  localparam int DivW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(Div - 1);
  localparam int AW   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  generate
    if (Div < 2) begin : g_div_check
      $error("oc_uart_rx: clock divider must be at least 2");
    end
    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_fifo_check
      $error("oc_uart_rx: FifoDepth must be a power of 2 and at least 2");
    end
    if (SyncStages < 2) begin : g_sync_check
      $error("oc_uart_rx: SyncStages must be at least 2");
    end
  endgenerate

  // ---------------------------------------------------------------- sync
  logic [SyncStages-1:0] sync_q;
  logic [SyncStages-1:0] primed_q;
  logic                  rx_s;
  logic                  sync_primed;

  // The sync chain resets to 1, so straight after reset rxS reads "idle"
  // even if the pin is low mid-frame. primed_q marks when every stage holds
  // a real pin sample; WaitIdle only trusts rxS from then on.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q   <= '1;
      primed_q <= '0;
    end else begin
      sync_q   <= {sync_q[SyncStages-2:0], rx};
      primed_q <= {primed_q[SyncStages-2:0], 1'b1};
    end
  end

  assign rx_s        = sync_q[SyncStages-1];
  assign sync_primed = primed_q[SyncStages-1];

  // ---------------------------------------------------------------- FSM
  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [3:0]      tick_q, tick_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            s7_q, s7_d;
  logic            s8_q, s8_d;
  logic            maj;
  logic            active;
  logic            strobe;
  logic            push;
  logic            frame_fail;
  logic            is_break;
  logic            error_frame_q;
  logic            overrun_q;

  // Majority vote of the samples taken at the ends of ticks 7, 8 and the live value at tick 9.
  assign maj = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_WAIT_IDLE;
      div_q   <= '0;
      tick_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      s7_q    <= 1'b1;
      s8_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    tick_d     = tick_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    s7_d       = s7_q;
    s8_d       = s8_q;
    push       = 1'b0;
    frame_fail = 1'b0;
    active     = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    // strobe marks the last clock of the current tick; all per-tick actions happen there.
    strobe     = active && (div_q == DivLast);

    if (active) begin
      div_d = (div_q == DivLast) ? '0 : div_q + 1'b1;
      if (strobe) begin
        tick_d = tick_q + 4'd1;
        if (tick_q == 4'd7) s7_d = rx_s;
        if (tick_q == 4'd8) s8_d = rx_s;
      end
    end

    case (state_q)
      S_WAIT_IDLE: begin
        if (sync_primed && rx_s) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          div_d   = '0;
          tick_d  = '0;
        end
      end
      S_START: begin
        if (strobe) begin
          if (tick_q == 4'd9 && maj) begin
            state_d = S_IDLE;
          end else if (tick_q == 4'd15) begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (strobe) begin
          if (tick_q == 4'd9) shreg_d[idx_q] = maj;
          if (tick_q == 4'd15) begin
            if (idx_q == 3'd7) state_d = S_STOP;
            else               idx_d   = idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        // Deciding at tick 9 leaves the rest of the stop bit for Idle to catch a back-to-back start edge.
        if (strobe && tick_q == 4'd9) begin
          if (maj) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_fail = 1'b1;
            state_d    = S_WAIT_IDLE;
          end
        end
      end
      default: state_d = S_WAIT_IDLE;
    endcase
  end

`ifdef OC_UART_RX_BREAK_DETECT_EN
  assign is_break = frame_fail && (shreg_q == 8'h00);
`else
  assign is_break = 1'b0;
`endif

  // ---------------------------------------------------------------- FIFO
  logic [7:0] mem_q [FifoDepth];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        full;
  logic        empty;
  logic        pop;
  logic        push_ok;
  logic        overrun;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && rxReady;
  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);
  assign overrun = push && full && !pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= 8'h00;
    end else begin
      if (push_ok) begin
        mem_q[wr_q[AW-1:0]] <= shreg_q;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  assign rxData  = mem_q[rd_q[AW-1:0]];
  assign rxValid = !empty;

  // ---------------------------------------------------------------- pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error_frame_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      error_frame_q <= frame_fail && !is_break;
      overrun_q     <= overrun;
    end
  end

  assign errorFrame   = error_frame_q;
  assign errorOverrun = overrun_q;

`ifdef OC_UART_RX_BREAK_DETECT_EN
  logic break_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) break_q <= 1'b0;
    else        break_q <= is_break;
  end

  assign breakDetect = break_q;
`else
  assign breakDetect = 1'b0;
`endif

endmodule

// File: tb/tb_oc_uart_rx.sv
// Bench for oc_uart_rx at ClockHz=32 MHz, Baud=1 Mbaud (32 clocks per bit).
// Frames are driven bit by bit; a negedge monitor records accepted bytes and pulse counts.
module tb_oc_uart_rx;

  localparam int BIT = 32;

`ifdef OC_UART_RX_BREAK_DETECT_EN
  localparam int BrkEn = 1;
`else
  localparam int BrkEn = 0;
`endif

  logic       clock;
  logic       reset;
  logic       rx;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;
  logic       errorFrame;
  logic       errorOverrun;
  logic       breakDetect;

  oc_uart_rx #(
    .ClockHz   (32_000_000),
    .Baud      (1_000_000),
    .FifoDepth (4),
    .SyncStages(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .rxData      (rxData),
    .rxValid     (rxValid),
    .rxReady     (rxReady),
    .errorFrame  (errorFrame),
    .errorOverrun(errorOverrun),
    .breakDetect (breakDetect)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // ---------------------------------------------------------------- monitor
  logic [7:0] got[$];
  int n_vld = 0;
  int n_fe  = 0;
  int n_or  = 0;
  int n_brk = 0;

  always @(negedge clock) begin
    if (rxValid && rxReady) got.push_back(rxData);
    if (rxValid)      n_vld++;
    if (errorFrame)   n_fe++;
    if (errorOverrun) n_or++;
    if (breakDetect)  n_brk++;
  end

  // 0: hold low, 1: hold high, 2: random each cycle
  int rdy_mode = 0;

  initial begin
    rxReady = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       rxReady = 1'b0;
        1:       rxReady = 1'b1;
        default: rxReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  task automatic hold_line(input int n);
    rx = 1'b1;
    if (n > 0) begin
      repeat (n) @(posedge clock);
      #1;
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         gap;
    int         exp_bytes;
    int         exp_fe;
    int         exp_brk;
  } vec_t;

  vec_t tbl[8];

  int b_got, b_vld, b_fe, b_or, b_brk;

  task automatic snap();
    b_got = got.size();
    b_vld = n_vld;
    b_fe  = n_fe;
    b_or  = n_or;
    b_brk = n_brk;
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    logic [7:0] exp_q[$];
    int         exp_fe;
    int         exp_brk;
    logic [7:0] d;
    logic       bad;
    int         gap;
    int         waited;

    tbl[0] = '{8'h55, 1'b1, 0,  1, 0, 0};
    tbl[1] = '{8'hA3, 1'b1, 64, 1, 0, 0};
    tbl[2] = '{8'h7E, 1'b0, 64, 0, 1, 0};
    tbl[3] = '{8'h12, 1'b1, 64, 1, 0, 0};
    tbl[4] = '{8'h00, 1'b1, 20, 1, 0, 0};
    tbl[5] = '{8'hFF, 1'b1, 0,  1, 0, 0};
    tbl[6] = '{8'h00, 1'b0, 64, 0, 1 - BrkEn, BrkEn};
    tbl[7] = '{8'h80, 1'b1, 64, 1, 0, 0};

    rx    = 1'b1;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("reset_rxValid", 32'(rxValid), 0);
    check("reset_rxData", 32'(rxData), 0);
    check("reset_errorFrame", 32'(errorFrame), 0);
    check("reset_errorOverrun", 32'(errorOverrun), 0);
    check("reset_breakDetect", 32'(breakDetect), 0);
    reset = 1'b1;
    hold_line(40);

    // Table: back-to-back good frames, framing errors, boundary data values.
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      snap();
      send_frame(tbl[i].d, tbl[i].stop);
      hold_line(tbl[i].gap);
      check($sformatf("tbl%0d_bytes", i), 32'(got.size() - b_got), 32'(tbl[i].exp_bytes));
      if (tbl[i].exp_bytes == 1 && got.size() > b_got)
        check($sformatf("tbl%0d_data", i), 32'(got[b_got]), 32'(tbl[i].d));
      check($sformatf("tbl%0d_valid_cycles", i), 32'(n_vld - b_vld), 32'(tbl[i].exp_bytes));
      check($sformatf("tbl%0d_errorFrame", i), 32'(n_fe - b_fe), 32'(tbl[i].exp_fe));
      check($sformatf("tbl%0d_breakDetect", i), 32'(n_brk - b_brk), 32'(tbl[i].exp_brk));
      check($sformatf("tbl%0d_errorOverrun", i), 32'(n_or - b_or), 0);
    end

    // Start-bit glitch of 8 clocks is rejected.
    snap();
    rx = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    hold_line(64);
    check("glitch_bytes", 32'(got.size() - b_got), 0);
    check("glitch_errors", 32'(n_fe - b_fe + n_brk - b_brk), 0);
    send_frame(8'h41, 1'b1);
    hold_line(64);
    check("glitch_then_bytes", 32'(got.size() - b_got), 1);
    if (got.size() > b_got) check("glitch_then_data", 32'(got[b_got]), 32'h41);

    // Overrun: five bytes into a four-entry FIFO with no consumer.
    rdy_mode = 0;
    hold_line(4);
    snap();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    hold_line(64);
    check("overrun_pulses", 32'(n_or - b_or), 1);
    check("overrun_rxValid", 32'(rxValid), 1);
    check("overrun_no_pop", 32'(got.size() - b_got), 0);
    rdy_mode = 1;
    waited = 0;
    while (got.size() < b_got + 4 && waited < 40) begin
      @(posedge clock);
      waited++;
    end
    hold_line(10);
    check("drain_count", 32'(got.size() - b_got), 4);
    for (int i = 0; i < 4; i++)
      if (got.size() > b_got + i)
        check($sformatf("drain_data%0d", i), 32'(got[b_got + i]), 32'(i + 1));
    check("drain_empty", 32'(rxValid), 0);
    check("drain_overrun_total", 32'(n_or - b_or), 1);

    // Break: line low for 12 bit times.
    snap();
    rx = 1'b0;
    repeat (12 * BIT) @(posedge clock);
    #1;
    hold_line(64);
    check("break_errorFrame", 32'(n_fe - b_fe), 32'(1 - BrkEn));
    check("break_breakDetect", 32'(n_brk - b_brk), 32'(BrkEn));
    check("break_bytes", 32'(got.size() - b_got), 0);
    send_frame(8'h33, 1'b1);
    hold_line(64);
    check("break_then_bytes", 32'(got.size() - b_got), 1);
    if (got.size() > b_got) check("break_then_data", 32'(got[b_got]), 32'h33);

    // Reset in bit 3 of 0xC3, released with the line still low.
    rdy_mode = 0;
    hold_line(4);
    snap();
    send_frame(8'h99, 1'b1);
    hold_line(16);
    check("pre_reset_rxValid", 32'(rxValid), 1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (16) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_rxValid", 32'(rxValid), 0);
    check("async_reset_rxData", 32'(rxData), 0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    rdy_mode = 1;
    repeat (13) @(posedge clock);
    #1;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    hold_line(64);
    check("midreset_bytes", 32'(got.size() - b_got), 0);
    check("midreset_errors", 32'(n_fe - b_fe + n_brk - b_brk + n_or - b_or), 0);
    send_frame(8'h5A, 1'b1);
    hold_line(64);
    check("midreset_then_bytes", 32'(got.size() - b_got), 1);
    if (got.size() > b_got) check("midreset_then_data", 32'(got[b_got]), 32'h5A);

    // Random frames with random consumer, checked against a frame-level model.
    rdy_mode = 2;
    snap();
    exp_fe  = 0;
    exp_brk = 0;
    for (int i = 0; i < 14; i++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      if (i == 9) begin
        d   = 8'h00;
        bad = 1'b1;
      end
      gap = bad ? $urandom_range(32, 90) : $urandom_range(0, 90);
      if (!bad)                    exp_q.push_back(d);
      else if (BrkEn && d == 8'h00) exp_brk++;
      else                         exp_fe++;
      send_frame(d, !bad);
      hold_line(gap);
    end
    hold_line(100);
    check("rand_count", 32'(got.size() - b_got), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (got.size() > b_got + i)
        check($sformatf("rand_data%0d", i), 32'(got[b_got + i]), 32'(exp_q[i]));
    check("rand_errorFrame", 32'(n_fe - b_fe), 32'(exp_fe));
    check("rand_breakDetect", 32'(n_brk - b_brk), 32'(exp_brk));
    check("rand_errorOverrun", 32'(n_or - b_or), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
